frogger_game_sched: RTL and testbench

//  Per-frame game sequencer for the Frogger renderer. It owns every time-varying value the pixel mux consumes:

---
 rtl/frogger_game_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_frogger_game_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_sched.sv
`default_nettype none
// ============================================================================
//  Module      : frogger_game_sched
//  Description : Per-frame game sequencer for the Frogger renderer. Owns the
//                lane obstacle positions, time bar, lives, score and game
//                state, advancing them once per frame_tick, and issues frog
//                respawn pulses.
//  Options     : FROGGER_PAUSE_EN adds the pause input / paused output and a
//                pause freeze that toggles on each pause rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module frogger_game_sched #(
  parameter int NUM_LANES    = 10,
  parameter int SCREEN_W     = 640,
  parameter int INIT_X       = 440,
  parameter int TIME_INIT    = 200,
  parameter int TIME_DIV     = 30,
  parameter int DEATH_FRAMES = 60,
  parameter int LIVES_INIT   = 3
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    frog_hit,
  input  logic                    frog_home,
  input  logic [NUM_LANES*4-1:0]  lane_period,
  input  logic [NUM_LANES-1:0]    lane_dir,
`ifdef FROGGER_PAUSE_EN
  input  logic                    pause,
  output logic                    paused,
`endif
  output logic [NUM_LANES*10-1:0] lane_x,
  output logic [9:0]              time_width,
  output logic [1:0]              lives,
  output logic [7:0]              score,
  output logic [1:0]              game_state,
  output logic                    frog_respawn
);

  localparam int c_PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam int c_DTH_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

  localparam logic [9:0]         c_INIT_X     = 10'(INIT_X);
  localparam logic [9:0]         c_X_MAX      = 10'(SCREEN_W - 1);
  localparam logic [9:0]         c_TIME_INIT  = 10'(TIME_INIT);
  localparam logic [1:0]         c_LIVES_INIT = 2'(LIVES_INIT);
  localparam logic [c_PRE_W-1:0] c_PRE_LAST   = c_PRE_W'(TIME_DIV - 1);
  localparam logic [c_DTH_W-1:0] c_DTH_LAST   = c_DTH_W'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_PLAY     = 2'b01,
    S_DEATH    = 2'b10,
    S_GAMEOVER = 2'b11
  } state_t;

  state_t             r_state, w_state;
  logic [9:0]         r_time, w_time;
  logic [c_PRE_W-1:0] r_pre, w_pre;
  logic [c_DTH_W-1:0] r_dcnt, w_dcnt;
  logic [1:0]         r_lives, w_lives;
  logic [7:0]         r_score, w_score;
  logic               r_respawn, w_respawn;

  logic               w_frozen;
  logic               w_run;
  logic               w_lane_reinit;

`ifdef FROGGER_PAUSE_EN
  logic r_pause_d;
  logic r_paused;
  logic w_pause_rise;

  // Only a live game (PLAY or DEATH) can be paused or resumed.
  assign w_pause_rise = pause & ~r_pause_d &
                        ((r_state == S_PLAY) | (r_state == S_DEATH));

  // Pause edge detector and freeze toggle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_pause_d <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_pause_d <= pause;
      if (w_pause_rise) begin
        r_paused <= ~r_paused;
      end
    end
  end

  assign w_frozen = r_paused;
  assign paused   = r_paused;
`else
  assign w_frozen = 1'b0;
`endif

  // A frame tick advances the game only while it is live and not frozen.
  assign w_run = frame_tick & ~w_frozen &
                 ((r_state == S_PLAY) | (r_state == S_DEATH));

  // New game from GAMEOVER puts every lane back to its start position.
  assign w_lane_reinit = (r_state == S_GAMEOVER) & start;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [3:0] w_p;
    logic [3:0] r_cnt, w_cnt;
    logic [9:0] r_x, w_x;

    assign w_p = lane_period[4*gi +: 4];

    // Lane step: counter runs to P-1 (or beyond after a period change), then steps and wraps.
    always_comb begin
      w_cnt = r_cnt;
      w_x   = r_x;
      if (w_lane_reinit) begin
        w_cnt = 4'd0;
        w_x   = c_INIT_X;
      end else if (w_run && (w_p != 4'd0)) begin
        if (r_cnt >= (w_p - 4'd1)) begin
          w_cnt = 4'd0;
          if (lane_dir[gi]) begin
            w_x = (r_x == c_X_MAX) ? 10'd0 : r_x + 10'd1;
          end else begin
            w_x = (r_x == 10'd0) ? c_X_MAX : r_x - 10'd1;
          end
        end else begin
          w_cnt = r_cnt + 4'd1;
        end
      end
    end

    // Lane position and step counter registers.
    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_cnt <= 4'd0;
        r_x   <= c_INIT_X;
      end else begin
        r_cnt <= w_cnt;
        r_x   <= w_x;
      end
    end

    assign lane_x[10*gi +: 10] = r_x;
  end

  // Game FSM next state plus time bar, lives, score and respawn next values.
  always_comb begin
    w_state   = r_state;
    w_time    = r_time;
    w_pre     = r_pre;
    w_dcnt    = r_dcnt;
    w_lives   = r_lives;
    w_score   = r_score;
    w_respawn = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state   = S_PLAY;
          w_respawn = 1'b1;
        end
      end
      S_PLAY: begin
        if (w_run) begin
          if (r_pre >= c_PRE_LAST) begin
            w_pre = '0;
            if (r_time != 10'd0) begin
              w_time = r_time - 10'd1;
            end
          end else begin
            w_pre = r_pre + 1'b1;
          end
          // A hit outranks reaching home on the same tick.
          if (frog_hit || (r_time == 10'd0)) begin
            if (r_lives <= 2'd1) begin
              w_lives = 2'd0;
              w_state = S_GAMEOVER;
            end else begin
              w_lives = r_lives - 2'd1;
              w_dcnt  = '0;
              w_state = S_DEATH;
            end
          end else if (frog_home) begin
            if (r_score != 8'hFF) begin
              w_score = r_score + 8'd1;
            end
            w_time    = c_TIME_INIT;
            w_pre     = '0;
            w_respawn = 1'b1;
          end
        end
      end
      S_DEATH: begin
        if (w_run) begin
          if (r_dcnt >= c_DTH_LAST) begin
            w_time    = c_TIME_INIT;
            w_pre     = '0;
            w_respawn = 1'b1;
            w_state   = S_PLAY;
          end else begin
            w_dcnt = r_dcnt + 1'b1;
          end
        end
      end
      S_GAMEOVER: begin
        if (start) begin
          w_time    = c_TIME_INIT;
          w_pre     = '0;
          w_dcnt    = '0;
          w_lives   = c_LIVES_INIT;
          w_score   = 8'd0;
          w_respawn = 1'b1;
          w_state   = S_PLAY;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Game state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Time bar, prescaler, death counter, lives, score and respawn registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_time    <= c_TIME_INIT;
      r_pre     <= '0;
      r_dcnt    <= '0;
      r_lives   <= c_LIVES_INIT;
      r_score   <= 8'd0;
      r_respawn <= 1'b0;
    end else begin
      r_time    <= w_time;
      r_pre     <= w_pre;
      r_dcnt    <= w_dcnt;
      r_lives   <= w_lives;
      r_score   <= w_score;
      r_respawn <= w_respawn;
    end
  end

  assign time_width   = r_time;
  assign lives        = r_lives;
  assign score        = r_score;
  assign game_state   = r_state;
  assign frog_respawn = r_respawn;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frogger_game_sched
//  Description : Self-checking bench for frogger_game_sched: directed game
//                scenarios followed by randomized play, every output compared
//                each cycle against a behavioural game model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frogger_game_sched;

  localparam int NL = 10;
  localparam int SW = 640;
  localparam int IX = 440;
  localparam int TI = 200;
  localparam int TD = 30;
  localparam int DF = 60;
  localparam int LI = 3;

  typedef logic [NL*10-1:0] vec_t;

  logic            Clk        = 1'b0;
  logic            Reset_n    = 1'b0;
  logic            frame_tick = 1'b0;
  logic            start      = 1'b0;
  logic            frog_hit   = 1'b0;
  logic            frog_home  = 1'b0;
  logic [NL*4-1:0] lane_period = '0;
  logic [NL-1:0]   lane_dir    = '0;
  logic [NL*10-1:0] lane_x;
  logic [9:0]      time_width;
  logic [1:0]      lives;
  logic [7:0]      score;
  logic [1:0]      game_state;
  logic            frog_respawn;
`ifdef FROGGER_PAUSE_EN
  logic            pause = 1'b0;
  logic            paused;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural game model: 0 idle, 1 play, 2 death, 3 game over.
  int m_state, m_time, m_pre, m_dcnt, m_lives, m_score;
  int m_x   [NL];
  int m_cnt [NL];   // frames elapsed since the lane last stepped
  bit m_resp, m_paused, m_pause_d;

  always #5 Clk = ~Clk;

  frogger_game_sched dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .start        (start),
    .frog_hit     (frog_hit),
    .frog_home    (frog_home),
    .lane_period  (lane_period),
    .lane_dir     (lane_dir),
`ifdef FROGGER_PAUSE_EN
    .pause        (pause),
    .paused       (paused),
`endif
    .lane_x       (lane_x),
    .time_width   (time_width),
    .lives        (lives),
    .score        (score),
    .game_state   (game_state),
    .frog_respawn (frog_respawn)
  );

  task automatic model_new_game();
    for (int i = 0; i < NL; i++) begin
      m_x[i]   = IX;
      m_cnt[i] = 0;
    end
    m_time  = TI;
    m_pre   = 0;
    m_dcnt  = 0;
    m_lives = LI;
    m_score = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    bit run, rise, pnow;
    int t0, p, st0;
    m_resp = 1'b0;
`ifdef FROGGER_PAUSE_EN
    pnow = pause;
`else
    pnow = 1'b0;
`endif
    if (!Reset_n) begin
      model_new_game();
      m_state   = 0;
      m_paused  = 1'b0;
      m_pause_d = 1'b0;
      return;
    end
    st0  = m_state;
    t0   = m_time;
    run  = frame_tick && (st0 == 1 || st0 == 2) && !m_paused;
    rise = pnow && !m_pause_d && (st0 == 1 || st0 == 2);
    if (run) begin
      for (int i = 0; i < NL; i++) begin
        p = int'(lane_period[4*i +: 4]);
        if (p != 0) begin
          m_cnt[i]++;
          if (m_cnt[i] >= p) begin
            m_cnt[i] = 0;
            m_x[i]   = (m_x[i] + (lane_dir[i] ? 1 : SW - 1)) % SW;
          end
        end
      end
    end
    case (st0)
      0: if (start) begin m_state = 1; m_resp = 1'b1; end
      1: if (run) begin
        m_pre++;
        if (m_pre >= TD) begin
          m_pre = 0;
          if (m_time > 0) m_time--;
        end
        if (frog_hit || t0 == 0) begin
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 2; m_dcnt = 0; end
        end else if (frog_home) begin
          if (m_score < 255) m_score++;
          m_time = TI;
          m_pre  = 0;
          m_resp = 1'b1;
        end
      end
      2: if (run) begin
        m_dcnt++;
        if (m_dcnt >= DF) begin
          m_time  = TI;
          m_pre   = 0;
          m_resp  = 1'b1;
          m_state = 1;
        end
      end
      default: if (start) begin
        model_new_game();
        m_resp  = 1'b1;
        m_state = 1;
      end
    endcase
    if (rise) m_paused = !m_paused;
    m_pause_d = pnow;
  endtask

  function automatic vec_t exp_lanes();
    vec_t v;
    for (int i = 0; i < NL; i++) v[10*i +: 10] = 10'(m_x[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("lane_x",       vec_t'(lane_x),       exp_lanes());
    chk("time_width",   vec_t'(time_width),   vec_t'(m_time));
    chk("lives",        vec_t'(lives),        vec_t'(m_lives));
    chk("score",        vec_t'(score),        vec_t'(m_score));
    chk("game_state",   vec_t'(game_state),   vec_t'(m_state));
    chk("frog_respawn", vec_t'(frog_respawn), vec_t'(m_resp));
`ifdef FROGGER_PAUSE_EN
    chk("paused",       vec_t'(paused),       vec_t'(m_paused));
`endif
  endtask

  // One clock: present inputs, take the edge, update the model, compare just after the edge.
  task automatic cyc(input bit tk, input bit hit, input bit home, input bit st);
    frame_tick = tk;
    frog_hit   = hit;
    frog_home  = home;
    start      = st;
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    vec_t all440, snap;
    for (int i = 0; i < NL; i++) all440[10*i +: 10] = 10'(IX);

    // Reset held two clocks, then idle without start.
    Reset_n = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0);
    chk("rst_state", vec_t'(game_state), vec_t'(0));
    chk("rst_lives", vec_t'(lives), vec_t'(3));
    chk("rst_time",  vec_t'(time_width), vec_t'(200));
    chk("rst_resp",  vec_t'(frog_respawn), vec_t'(0));
    Reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      cyc(0, 0, 0, 0);
    end
    chk("idle_state", vec_t'(game_state), vec_t'(0));
    chk("idle_lanes", vec_t'(lane_x), all440);
    chk("idle_time",  vec_t'(time_width), vec_t'(200));

    // Start; lane0 right every frame, lane1 left every second frame.
    lane_period      = '0;
    lane_period[3:0] = 4'd1;
    lane_period[7:4] = 4'd2;
    lane_dir         = '0;
    lane_dir[0]      = 1'b1;
    cyc(0, 0, 0, 1);
    chk("start_state", vec_t'(game_state), vec_t'(1));
    chk("start_resp",  vec_t'(frog_respawn), vec_t'(1));
    for (int k = 0; k < 10; k++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 1, 1, 0);
    end
    chk("lane0_10", vec_t'(lane_x[9:0]),   vec_t'(450));
    chk("lane1_10", vec_t'(lane_x[19:10]), vec_t'(435));
    for (int k = 0; k < 189; k++) cyc(1, 0, 0, 0);
    chk("lane0_639",  vec_t'(lane_x[9:0]), vec_t'(639));
    cyc(1, 0, 0, 0);
    chk("lane0_wrap", vec_t'(lane_x[9:0]), vec_t'(0));

    // Home: score and time bar refilled.
    cyc(1, 0, 1, 0);
    chk("home_score", vec_t'(score), vec_t'(1));
    chk("home_time",  vec_t'(time_width), vec_t'(200));
    chk("home_resp",  vec_t'(frog_respawn), vec_t'(1));

    // Hit and home on one tick: hit only.
    cyc(1, 1, 1, 0);
    chk("hh_lives", vec_t'(lives), vec_t'(2));
    chk("hh_score", vec_t'(score), vec_t'(1));
    chk("hh_state", vec_t'(game_state), vec_t'(2));
    for (int k = 0; k < DF - 1; k++) cyc(1, 0, 1, 1);
    chk("death_hold", vec_t'(game_state), vec_t'(2));
    cyc(1, 0, 0, 0);
    chk("death_resp",  vec_t'(frog_respawn), vec_t'(1));
    chk("death_state", vec_t'(game_state), vec_t'(1));

    // Time bar runs out.
    for (int k = 0; k < 7000 && m_state == 1; k++) cyc(1, 0, 0, 0);
    chk("to_state", vec_t'(game_state), vec_t'(2));
    chk("to_lives", vec_t'(lives), vec_t'(1));
    chk("to_time",  vec_t'(time_width), vec_t'(0));
    for (int k = 0; k < DF - 1; k++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("to_resp",  vec_t'(frog_respawn), vec_t'(1));
    chk("to_time2", vec_t'(time_width), vec_t'(200));
    chk("to_play",  vec_t'(game_state), vec_t'(1));

    // Last life lost: game over, everything frozen, then restart.
    cyc(1, 1, 0, 0);
    chk("go_state", vec_t'(game_state), vec_t'(3));
    chk("go_lives", vec_t'(lives), vec_t'(0));
    snap = exp_lanes();
    for (int k = 0; k < 20; k++) cyc(1, 1, 1, 0);
    chk("go_frozen", vec_t'(lane_x), snap);
    cyc(0, 0, 0, 1);
    chk("rs_lives", vec_t'(lives), vec_t'(3));
    chk("rs_score", vec_t'(score), vec_t'(0));
    chk("rs_lanes", vec_t'(lane_x), all440);
    chk("rs_state", vec_t'(game_state), vec_t'(1));
    chk("rs_resp",  vec_t'(frog_respawn), vec_t'(1));
    cyc(0, 0, 0, 1);
    chk("rs_resp1", vec_t'(frog_respawn), vec_t'(0));

    // Reset in the middle of DEATH.
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    for (int k = 0; k < 7; k++) cyc(1, 0, 0, 0);
    Reset_n = 1'b0;
    cyc(1, 0, 1, 1);
    chk("mrst_state", vec_t'(game_state), vec_t'(0));
    chk("mrst_lives", vec_t'(lives), vec_t'(3));
    chk("mrst_lanes", vec_t'(lane_x), all440);
    chk("mrst_time",  vec_t'(time_width), vec_t'(200));
    Reset_n = 1'b1;

`ifdef FROGGER_PAUSE_EN
    // Pause freezes lanes; second rising edge resumes.
    cyc(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
    pause = 1'b1;
    cyc(0, 0, 0, 0);
    snap = exp_lanes();
    for (int k = 0; k < 50; k++) cyc(1, 0, 0, 0);
    chk("pause_frozen", vec_t'(lane_x), snap);
    pause = 1'b0;
    cyc(0, 0, 0, 0);
    pause = 1'b1;
    cyc(0, 0, 0, 0);
    pause = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0);
`endif

    // Randomized play with period changes, starts and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        lane_period = 40'({$urandom(), $urandom()});
        lane_dir    = 10'($urandom());
      end
`ifdef FROGGER_PAUSE_EN
      if ($urandom_range(0, 29) == 0) pause = ~pause;
`endif
      Reset_n = ($urandom_range(0, 499) != 0);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    Reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
